alu_issue_ctrl: RTL and testbench

//  Sequencer that drives the ALU: accepts one instruction per valid/ready handshake and

---
 rtl/alu_pkg.sv | 76 +++++++
 rtl/alu_regfile.sv | 39 +++
 rtl/alu_issue_ctrl.sv | 178 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction classes,
// status flag positions and sequencer states.
package alu_pkg;

  localparam logic [4:0] OP_NOT   = 5'd0;
  localparam logic [4:0] OP_AND   = 5'd1;
  localparam logic [4:0] OP_OR    = 5'd2;
  localparam logic [4:0] OP_XOR   = 5'd3;
  localparam logic [4:0] OP_SHL   = 5'd4;
  localparam logic [4:0] OP_SHR   = 5'd5;
  localparam logic [4:0] OP_INC   = 5'd6;
  localparam logic [4:0] OP_DEC   = 5'd7;
  localparam logic [4:0] OP_ROTR  = 5'd8;
  localparam logic [4:0] OP_ROTL  = 5'd9;
  localparam logic [4:0] OP_SWAP  = 5'd10;
  localparam logic [4:0] OP_ADD   = 5'd11;
  localparam logic [4:0] OP_ADDC  = 5'd12;
  localparam logic [4:0] OP_SUB   = 5'd13;
  localparam logic [4:0] OP_SUBB  = 5'd14;
  localparam logic [4:0] OP_EQ    = 5'd15;
  localparam logic [4:0] OP_GT    = 5'd16;
  localparam logic [4:0] OP_LT    = 5'd17;
  localparam logic [4:0] OP_GE    = 5'd18;
  localparam logic [4:0] OP_LE    = 5'd19;
  localparam logic [4:0] OP_JMP   = 5'd20;
  localparam logic [4:0] OP_JZ    = 5'd21;
  localparam logic [4:0] OP_JS    = 5'd22;
  localparam logic [4:0] OP_JZS   = 5'd23;
  localparam logic [4:0] OP_LDSR  = 5'd24;
  localparam logic [4:0] OP_XORSR = 5'd25;
  localparam logic [4:0] OP_NOP   = 5'd26;
  localparam logic [4:0] OP_TRAP  = 5'd27;

  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_TRAP = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    CLS_LOGIC = 4'd0,
    CLS_SHIFT = 4'd1,
    CLS_ROT   = 4'd2,
    CLS_SWAP  = 4'd3,
    CLS_ARITH = 4'd4,
    CLS_CMP   = 4'd5,
    CLS_JUMP  = 4'd6,
    CLS_LDSR  = 4'd7,
    CLS_XORSR = 4'd8,
    CLS_NOP   = 4'd9,
    CLS_TRAP  = 4'd10
  } op_class_e;

  // Undefined opcodes fall into the trap class
  function automatic op_class_e op_class(input logic [4:0] op);
    case (op)
      OP_NOT, OP_AND, OP_OR, OP_XOR:         op_class = CLS_LOGIC;
      OP_SHL, OP_SHR, OP_INC, OP_DEC:        op_class = CLS_SHIFT;
      OP_ROTR, OP_ROTL:                      op_class = CLS_ROT;
      OP_SWAP:                               op_class = CLS_SWAP;
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBB:      op_class = CLS_ARITH;
      OP_EQ, OP_GT, OP_LT, OP_GE, OP_LE:     op_class = CLS_CMP;
      OP_JMP, OP_JZ, OP_JS, OP_JZS:          op_class = CLS_JUMP;
      OP_LDSR:                               op_class = CLS_LDSR;
      OP_XORSR:                              op_class = CLS_XORSR;
      OP_NOP:                                op_class = CLS_NOP;
      default:                               op_class = CLS_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for the issue controller: two asynchronous read ports and two
// synchronous write ports, cleared by the asynchronous reset.
module alu_regfile #(
  parameter int NREGS  = 8,
  parameter int WORD_W = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] raddr0,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  output logic [WORD_W-1:0]        rdata0,
  output logic [WORD_W-1:0]        rdata1,
  input  logic                     we0,
  input  logic [$clog2(NREGS)-1:0] waddr0,
  input  logic [WORD_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [$clog2(NREGS)-1:0] waddr1,
  input  logic [WORD_W-1:0]        wdata1
);
  localparam int IDX_W = $clog2(NREGS);

  logic [WORD_W-1:0] mem_r [NREGS];

  assign rdata0 = mem_r[raddr0];
  assign rdata1 = mem_r[raddr1];

  // Both ports commit on the same edge; port 0 wins when they hit the same entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_r[i] <= {WORD_W{1'b0}};
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we0 && (waddr0 == IDX_W'(i))) mem_r[i] <= wdata0;
        else if (we1 && (waddr1 == IDX_W'(i))) mem_r[i] <= wdata1;
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the ALU: accepts one instruction at a time, holds its operands
// stable for the ALU, then commits results, status flags and program-flow effects.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WORD_W   = 20,
  parameter int HALF_W   = 10,
  parameter int NREGS    = 8,
  parameter int EXEC_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [4:0]               instr_op,
  input  logic                     instr_mode,
  input  logic [$clog2(NREGS)-1:0] instr_rd,
  input  logic [$clog2(NREGS)-1:0] instr_rs,
  input  logic [WORD_W-1:0]        instr_imm,
  output logic [4:0]               alu_op_o,
  output logic                     alu_mode_o,
  output logic [WORD_W-1:0]        alu_a_o,
  output logic [WORD_W-1:0]        alu_b_o,
  input  logic [WORD_W-1:0]        alu_res_i,
  input  logic [WORD_W-1:0]        alu_res2_i,
  input  logic                     alu_zero_i,
  input  logic                     alu_sign_i,
  input  logic                     alu_carry_i,
  output logic                     pc_load,
  output logic [WORD_W-1:0]        pc_target,
  output logic [2:0]               status_o,
  output logic                     trap_o
);
  localparam int IDX_W = $clog2(NREGS);
  localparam int CNT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_LAT - 1);

  state_e            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [IDX_W-1:0]  rd_r, rs_r;
  logic [WORD_W-1:0] imm_r;
  logic [2:0]        status_r, status_nxt_s;
  op_class_e         cls_s;
  logic              accept_s, jump_s, we0_s, we1_s, res_msb_s;
  logic [WORD_W-1:0] rdata0_s, rdata1_s, wdata0_s, wdata1_s;

  assign instr_ready = (state_r == ST_IDLE);
  assign accept_s    = instr_valid && instr_ready;
  assign cls_s       = op_class(alu_op_o);
  assign status_o    = status_r;

  // Half-word results never leak anything above HALF_W into the register file
  assign wdata0_s  = alu_mode_o ? alu_res_i  : {{(WORD_W-HALF_W){1'b0}}, alu_res_i[HALF_W-1:0]};
  assign wdata1_s  = alu_mode_o ? alu_res2_i : {{(WORD_W-HALF_W){1'b0}}, alu_res2_i[HALF_W-1:0]};
  assign res_msb_s = alu_mode_o ? alu_res_i[WORD_W-1] : alu_res_i[HALF_W-1];

  alu_regfile #(.NREGS(NREGS), .WORD_W(WORD_W)) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr0 (instr_rd),
    .raddr1 (instr_rs),
    .rdata0 (rdata0_s),
    .rdata1 (rdata1_s),
    .we0    (we0_s),
    .waddr0 (rd_r),
    .wdata0 (wdata0_s),
    .we1    (we1_s),
    .waddr1 (rs_r),
    .wdata1 (wdata1_s)
  );

  // Sequencer next state; TRAP is left only through reset
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: if (accept_s) state_nxt_s = ST_EXEC; else state_nxt_s = ST_IDLE;
      ST_EXEC: if (cnt_r == {CNT_W{1'b0}}) state_nxt_s = ST_WB; else state_nxt_s = ST_EXEC;
      ST_WB:   if (cls_s == CLS_TRAP) state_nxt_s = ST_TRAP; else state_nxt_s = ST_IDLE;
      ST_TRAP: state_nxt_s = ST_TRAP;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Writeback enables, flag update and jump resolution for the instruction in WB
  always_comb begin
    status_nxt_s = status_r;
    jump_s       = 1'b0;
    we0_s        = 1'b0;
    we1_s        = 1'b0;
    if (state_r == ST_WB) begin
      case (cls_s)
        CLS_LOGIC: begin
          we0_s = 1'b1;
          status_nxt_s[FLAG_Z] = alu_zero_i;
        end
        CLS_SHIFT: begin
          we0_s = 1'b1;
          status_nxt_s[FLAG_Z] = alu_zero_i;
          status_nxt_s[FLAG_C] = alu_carry_i;
        end
        CLS_ROT: we0_s = 1'b1;
        CLS_SWAP: begin
          // Swapping a register with itself leaves it untouched
          if (rd_r != rs_r) begin
            we0_s = 1'b1;
            we1_s = 1'b1;
          end else begin
            we0_s = 1'b0;
            we1_s = 1'b0;
          end
        end
        CLS_ARITH: begin
          we0_s = 1'b1;
          status_nxt_s[FLAG_Z] = alu_zero_i;
          status_nxt_s[FLAG_C] = alu_carry_i;
          status_nxt_s[FLAG_S] = res_msb_s;
        end
        CLS_CMP: begin
          status_nxt_s[FLAG_Z] = alu_zero_i;
          status_nxt_s[FLAG_S] = alu_sign_i;
        end
        CLS_JUMP: begin
          case (alu_op_o)
            OP_JMP:  jump_s = 1'b1;
            OP_JZ:   jump_s = status_r[FLAG_Z];
            OP_JS:   jump_s = status_r[FLAG_S];
            OP_JZS:  jump_s = status_r[FLAG_Z] & status_r[FLAG_S];
            default: jump_s = 1'b0;
          endcase
        end
        CLS_LDSR:  status_nxt_s = imm_r[2:0];
        CLS_XORSR: status_nxt_s = status_r ^ imm_r[2:0];
        CLS_NOP:   status_nxt_s = status_r;
        default:   status_nxt_s = status_r;
      endcase
    end else begin
      status_nxt_s = status_r;
    end
  end

  // State, instruction latch, ALU drive and committed outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      rd_r       <= {IDX_W{1'b0}};
      rs_r       <= {IDX_W{1'b0}};
      imm_r      <= {WORD_W{1'b0}};
      alu_op_o   <= 5'd0;
      alu_mode_o <= 1'b0;
      alu_a_o    <= {WORD_W{1'b0}};
      alu_b_o    <= {WORD_W{1'b0}};
      status_r   <= 3'b000;
      pc_load    <= 1'b0;
      pc_target  <= {WORD_W{1'b0}};
      trap_o     <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      status_r <= status_nxt_s;
      pc_load  <= jump_s;
      if (jump_s) pc_target <= imm_r;
      if ((state_r == ST_WB) && (cls_s == CLS_TRAP)) trap_o <= 1'b1;
      if (accept_s) begin
        cnt_r      <= CNT_LOAD;
        rd_r       <= instr_rd;
        rs_r       <= instr_rs;
        imm_r      <= instr_imm;
        alu_op_o   <= instr_op;
        alu_mode_o <= instr_mode;
        alu_a_o    <= rdata0_s;
        alu_b_o    <= rdata1_s;
      end else if ((state_r == ST_EXEC) && (cnt_r != {CNT_W{1'b0}})) begin
        cnt_r <= cnt_r - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus random instruction
// streams against a register/status reference model; the bench plays the ALU.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int WORD_W   = 20;
  localparam int HALF_W   = 10;
  localparam int NREGS    = 8;
  localparam int EXEC_LAT = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [4:0]        instr_op = 5'd0;
  logic              instr_mode = 1'b0;
  logic [2:0]        instr_rd = 3'd0;
  logic [2:0]        instr_rs = 3'd0;
  logic [WORD_W-1:0] instr_imm = '0;
  logic [4:0]        alu_op_o;
  logic              alu_mode_o;
  logic [WORD_W-1:0] alu_a_o, alu_b_o;
  logic [WORD_W-1:0] alu_res_i = '0;
  logic [WORD_W-1:0] alu_res2_i = '0;
  logic              alu_zero_i = 1'b0;
  logic              alu_sign_i = 1'b0;
  logic              alu_carry_i = 1'b0;
  logic              pc_load;
  logic [WORD_W-1:0] pc_target;
  logic [2:0]        status_o;
  logic              trap_o;

  int checks = 0;
  int failures = 0;

  logic [WORD_W-1:0] m_regs [NREGS];
  logic [2:0]        m_status;
  logic              m_trap;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WORD_W(WORD_W), .HALF_W(HALF_W), .NREGS(NREGS), .EXEC_LAT(EXEC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_mode(instr_mode), .instr_rd(instr_rd), .instr_rs(instr_rs),
    .instr_imm(instr_imm), .alu_op_o(alu_op_o), .alu_mode_o(alu_mode_o), .alu_a_o(alu_a_o),
    .alu_b_o(alu_b_o), .alu_res_i(alu_res_i), .alu_res2_i(alu_res2_i), .alu_zero_i(alu_zero_i),
    .alu_sign_i(alu_sign_i), .alu_carry_i(alu_carry_i), .pc_load(pc_load), .pc_target(pc_target),
    .status_o(status_o), .trap_o(trap_o)
  );

  function automatic logic [WORD_W-1:0] fit(input logic [WORD_W-1:0] v, input logic mode);
    return mode ? v : WORD_W'(v % (1 << HALF_W));
  endfunction

  // Reference effect of one committed instruction; status bits are {C,S,Z}
  task automatic model_wb(input logic [4:0] op, input logic mode, input logic [2:0] rd,
                          input logic [2:0] rs, input logic [WORD_W-1:0] imm,
                          input logic [WORD_W-1:0] res, input logic [WORD_W-1:0] res2,
                          input logic z, input logic s, input logic c, output logic jmp);
    logic [2:0] st;
    st  = m_status;
    jmp = 1'b0;
    if (op inside {OP_NOT, OP_AND, OP_OR, OP_XOR}) begin
      m_regs[rd] = fit(res, mode); st[0] = z;
    end else if (op inside {OP_SHL, OP_SHR, OP_INC, OP_DEC}) begin
      m_regs[rd] = fit(res, mode); st[0] = z; st[2] = c;
    end else if (op inside {OP_ROTR, OP_ROTL}) begin
      m_regs[rd] = fit(res, mode);
    end else if (op == OP_SWAP) begin
      if (rd != rs) begin
        m_regs[rd] = fit(res, mode); m_regs[rs] = fit(res2, mode);
      end
    end else if (op inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBB}) begin
      m_regs[rd] = fit(res, mode); st[0] = z; st[2] = c;
      st[1] = res[mode ? WORD_W-1 : HALF_W-1];
    end else if (op inside {OP_EQ, OP_GT, OP_LT, OP_GE, OP_LE}) begin
      st[0] = z; st[1] = s;
    end else if (op == OP_JMP) jmp = 1'b1;
    else if (op == OP_JZ)  jmp = m_status[0];
    else if (op == OP_JS)  jmp = m_status[1];
    else if (op == OP_JZS) jmp = m_status[0] & m_status[1];
    else if (op == OP_LDSR)  st = imm[2:0];
    else if (op == OP_XORSR) st = m_status ^ imm[2:0];
    else if (op == OP_NOP) st = m_status;
    else m_trap = 1'b1;
    m_status = st;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_status = 3'b000;
    m_trap = 1'b0;
    @(negedge clk);
  endtask

  // Issues one instruction with the given ALU response and checks the whole round trip
  task automatic issue(input logic [4:0] op, input logic mode, input logic [2:0] rd,
                       input logic [2:0] rs, input logic [WORD_W-1:0] imm,
                       input logic [WORD_W-1:0] res, input logic [WORD_W-1:0] res2,
                       input logic z, input logic s, input logic c);
    int guard;
    logic exp_jmp;
    logic [2:0] old_status;
    guard = 0;
    while (instr_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_wait got=%b exp=1", instr_ready);
    end else begin
      instr_valid = 1'b1; instr_op = op; instr_mode = mode;
      instr_rd = rd; instr_rs = rs; instr_imm = imm;
      alu_res_i = res; alu_res2_i = res2;
      alu_zero_i = z; alu_sign_i = s; alu_carry_i = c;
      old_status = m_status;
      @(negedge clk);
      checks++;
      if ({alu_op_o, alu_mode_o} !== {op, mode}) begin
        failures++;
        $display("FAIL alu_op got=%h/%b exp=%h/%b", alu_op_o, alu_mode_o, op, mode);
      end
      checks++;
      if (alu_a_o !== m_regs[rd]) begin
        failures++;
        $display("FAIL operand_a r%0d got=%h exp=%h", rd, alu_a_o, m_regs[rd]);
      end
      checks++;
      if (alu_b_o !== m_regs[rs]) begin
        failures++;
        $display("FAIL operand_b r%0d got=%h exp=%h", rs, alu_b_o, m_regs[rs]);
      end
      for (int i = 0; i <= EXEC_LAT; i++) begin
        // junk offered while busy must be ignored
        instr_valid = 1'b1;
        instr_op = 5'($urandom); instr_rd = 3'($urandom); instr_rs = 3'($urandom);
        instr_imm = WORD_W'($urandom);
        checks++;
        if ({instr_ready, pc_load, status_o} !== {2'b00, old_status}) begin
          failures++;
          $display("FAIL busy_phase got=%b%b/%b exp=00/%b", instr_ready, pc_load, status_o, old_status);
        end
        @(negedge clk);
      end
      instr_valid = 1'b0;
      model_wb(op, mode, rd, rs, imm, res, res2, z, s, c, exp_jmp);
      checks++;
      if (pc_load !== exp_jmp) begin
        failures++;
        $display("FAIL pc_load op=%0d got=%b exp=%b", op, pc_load, exp_jmp);
      end
      if (exp_jmp) begin
        checks++;
        if (pc_target !== imm) begin
          failures++;
          $display("FAIL pc_target got=%h exp=%h", pc_target, imm);
        end
      end
      checks++;
      if ({status_o, trap_o, instr_ready} !== {m_status, m_trap, ~m_trap}) begin
        failures++;
        $display("FAIL after_wb op=%0d got=%b/%b/%b exp=%b/%b/%b", op, status_o, trap_o,
                 instr_ready, m_status, m_trap, ~m_trap);
      end
      @(negedge clk);
      checks++;
      if (pc_load !== 1'b0) begin
        failures++;
        $display("FAIL pc_pulse_width got=%b exp=0", pc_load);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({instr_ready, pc_load, trap_o, status_o} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=100000", {instr_ready, pc_load, trap_o, status_o});
    end
    checks++;
    if ({alu_op_o, alu_a_o, alu_b_o, pc_target} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0", alu_op_o, alu_a_o, alu_b_o, pc_target);
    end
    for (int i = 0; i < NREGS; i += 2) issue(OP_NOP, 1'b1, 3'(i), 3'(i + 1), '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_add_full();
    issue(OP_ROTR, 1'b1, 3'd1, 3'd1, '0, 20'hFFFFF, '0, 1'b0, 1'b0, 1'b0);
    issue(OP_ROTR, 1'b1, 3'd2, 3'd2, '0, 20'h00001, '0, 1'b0, 1'b0, 1'b0);
    issue(OP_ADD, 1'b1, 3'd1, 3'd2, '0, 20'h00000, '0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (status_o !== 3'b101) begin
      failures++;
      $display("FAIL add_status got=%b exp=101", status_o);
    end
    issue(OP_NOP, 1'b1, 3'd1, 3'd2, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_half_inc();
    issue(OP_ROTR, 1'b1, 3'd3, 3'd3, '0, 20'h003FF, '0, 1'b0, 1'b0, 1'b0);
    issue(OP_INC, 1'b0, 3'd3, 3'd3, '0, 20'hFFC00, '0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (status_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL half_inc_z got=%b exp=1", status_o[0]);
    end
    issue(OP_NOP, 1'b1, 3'd3, 3'd3, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_swap();
    issue(OP_ROTR, 1'b1, 3'd1, 3'd1, '0, 20'hAAAAA, '0, 1'b0, 1'b0, 1'b0);
    issue(OP_ROTR, 1'b1, 3'd2, 3'd2, '0, 20'h55555, '0, 1'b0, 1'b0, 1'b0);
    issue(OP_SWAP, 1'b1, 3'd1, 3'd2, '0, 20'h55555, 20'hAAAAA, 1'b0, 1'b0, 1'b0);
    issue(OP_NOP, 1'b1, 3'd1, 3'd2, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    issue(OP_ROTR, 1'b1, 3'd4, 3'd4, '0, 20'h12345, '0, 1'b0, 1'b0, 1'b0);
    issue(OP_SWAP, 1'b1, 3'd4, 3'd4, '0, 20'h11111, 20'h22222, 1'b0, 1'b0, 1'b0);
    issue(OP_NOP, 1'b1, 3'd4, 3'd4, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_flow();
    issue(OP_LDSR, 1'b1, 3'd0, 3'd0, 20'h00001, '0, '0, 1'b0, 1'b0, 1'b0);
    issue(OP_JZ, 1'b1, 3'd0, 3'd0, 20'h00123, '0, '0, 1'b0, 1'b0, 1'b0);
    issue(OP_JS, 1'b1, 3'd0, 3'd0, 20'h00456, '0, '0, 1'b0, 1'b0, 1'b0);
    issue(OP_XORSR, 1'b1, 3'd0, 3'd0, 20'h00007, '0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (status_o !== 3'b110) begin
      failures++;
      $display("FAIL xorsr got=%b exp=110", status_o);
    end
    issue(OP_JZS, 1'b1, 3'd0, 3'd0, 20'h00789, '0, '0, 1'b0, 1'b0, 1'b0);
    issue(OP_LDSR, 1'b1, 3'd0, 3'd0, 20'hFFFF3, '0, '0, 1'b0, 1'b0, 1'b0);
    issue(OP_JZS, 1'b1, 3'd0, 3'd0, 20'h0ABCD, '0, '0, 1'b0, 1'b0, 1'b0);
    issue(OP_JMP, 1'b1, 3'd0, 3'd0, 20'h54321, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      issue(5'($urandom_range(0, 26)), 1'($urandom), 3'($urandom), 3'($urandom),
            WORD_W'($urandom), WORD_W'($urandom), WORD_W'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < NREGS; i += 2) issue(OP_NOP, 1'b1, 3'(i), 3'(i + 1), '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    int cyc;
    cyc = 0;
    instr_valid = 1'b1; instr_op = OP_NOP; instr_mode = 1'b1; instr_rd = 3'd5; instr_rs = 3'd6;
    while (acc_cyc.size() < 3 && cyc < 40) begin
      if (instr_ready === 1'b1) acc_cyc.push_back(cyc);
      @(negedge clk);
      cyc++;
    end
    instr_valid = 1'b0;
    checks++;
    if (acc_cyc.size() != 3) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=3", acc_cyc.size());
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != EXEC_LAT + 2) begin
        failures++;
        $display("FAIL b2b_spacing got=%0d exp=%0d", acc_cyc[i] - acc_cyc[i-1], EXEC_LAT + 2);
      end
    end
    repeat (EXEC_LAT + 2) @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    issue(OP_ROTR, 1'b1, 3'd1, 3'd1, '0, 20'h00005, '0, 1'b0, 1'b0, 1'b0);
    issue(OP_ROTR, 1'b1, 3'd2, 3'd2, '0, 20'h00003, '0, 1'b0, 1'b0, 1'b0);
    instr_valid = 1'b1; instr_op = OP_ADD; instr_mode = 1'b1; instr_rd = 3'd1; instr_rs = 3'd2;
    alu_res_i = 20'h00008; alu_zero_i = 1'b0; alu_carry_i = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    checks++;
    if ({alu_a_o, alu_b_o} !== {20'h00005, 20'h00003}) begin
      failures++;
      $display("FAIL mid_exec_operands got=%h/%h exp=00005/00003", alu_a_o, alu_b_o);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pc_load !== 1'b0) begin
        failures++;
        $display("FAIL mid_exec_pc_load got=%b exp=0", pc_load);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_status = 3'b000;
    m_trap = 1'b0;
    @(negedge clk);
    checks++;
    if (status_o !== 3'b000) begin
      failures++;
      $display("FAIL mid_exec_status got=%b exp=000", status_o);
    end
    issue(OP_NOP, 1'b1, 3'd1, 3'd2, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_trap();
    issue(OP_TRAP, 1'b1, 3'd0, 3'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    instr_valid = 1'b1; instr_op = OP_ROTR; instr_rd = 3'd0; instr_rs = 3'd0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({instr_ready, trap_o} !== 2'b01) begin
        failures++;
        $display("FAIL trap_hold got=%b%b exp=01", instr_ready, trap_o);
      end
      @(negedge clk);
    end
    do_reset();
    checks++;
    if ({instr_ready, trap_o} !== 2'b10) begin
      failures++;
      $display("FAIL trap_cleared got=%b%b exp=10", instr_ready, trap_o);
    end
    issue(5'd30, 1'b1, 3'd0, 3'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    do_reset();
  endtask

  initial begin
    test_reset();
    test_add_full();
    test_half_inc();
    test_swap();
    test_flow();
    test_random();
    test_back_to_back();
    test_reset_mid_exec();
    test_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

endmodule
